// File: rtl/rf_wr_sched.sv
// rf_wr_sched: shares the single register-file write port between the
// pipeline WB stage and a buffered long-latency result stream, and keeps a
// pending-destination scoreboard for decode hazard detection.
module rf_wr_sched #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  // pipeline writeback
  input  logic        WB_WE,
  input  logic [4:0]  WB_ADDR,
  input  logic [31:0] WB_DATA,
  output logic        WB_HOLD,
  // long-latency unit
  input  logic        LL_ISSUE,
  input  logic [4:0]  LL_ISSUE_ADDR,
  input  logic        LL_VALID,
  input  logic [4:0]  LL_ADDR,
  input  logic [31:0] LL_DATA,
  output logic        LL_READY,
  // decode hazard interface
  input  logic [4:0]  ID_RA1,
  input  logic [4:0]  ID_RA2,
  input  logic [4:0]  ID_WA,
  input  logic        ID_WE,
  output logic        STALL,
  output logic [31:0] PENDING,
  // register file write port
  output logic        RF_WE,
  output logic [4:0]  RF_WA,
  output logic [31:0] RF_WD
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [3:0]    LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [3:0]    STARVE_MAX = 4'hF;

  // ------------------------------------------------------------------
  // FIFO control state
  // ------------------------------------------------------------------
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  logic [4:0]    ent_addr [FIFO_DEPTH];
  logic [31:0]   ent_data [FIFO_DEPTH];

  // Occupancy flags come from registered state only, so a same-cycle pop
  // never lets a full buffer accept a new result.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
  end

  // Handshake: WB owns the port whenever it writes; the head drains otherwise.
  always_comb begin
    push = LL_VALID && !fifo_full;
    pop  = !WB_WE && !fifo_empty;
  end

  // Pointer and occupancy update; pointers wrap naturally at FIFO_DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ------------------------------------------------------------------
  // FIFO storage: one register pair per entry. Payload needs no reset
  // because occupancy alone decides whether an entry is meaningful.
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [4:0]  addr_q, addr_d;
      logic [31:0] data_q, data_d;
      logic        wr_sel;

      // Capture the incoming result when this slot is the write target.
      always_comb begin
        wr_sel = push && (wr_ptr_q == PW'(gi));
        addr_d = wr_sel ? LL_ADDR : addr_q;
        data_d = wr_sel ? LL_DATA : data_q;
      end

      // Entry payload registers.
      always_ff @(posedge CLK) begin
        addr_q <= addr_d;
        data_q <= data_d;
      end

      assign ent_addr[gi] = addr_q;
      assign ent_data[gi] = data_q;
    end
  endgenerate

  // Head of queue; a freshly pushed entry is only visible after its edge.
  always_comb begin
    head_addr = ent_addr[rd_ptr_q];
    head_data = ent_data[rd_ptr_q];
  end

  // ------------------------------------------------------------------
  // Write port select
  // ------------------------------------------------------------------
  // WB has absolute priority; r0 writes are suppressed but still consume
  // their slot; reset forces the enable low regardless of other inputs.
  always_comb begin
    RF_WE = 1'b0;
    RF_WA = 5'd0;
    RF_WD = 32'd0;
    if (WB_WE) begin
      RF_WE = (WB_ADDR != 5'd0);
      RF_WA = WB_ADDR;
      RF_WD = WB_DATA;
    end else if (!fifo_empty) begin
      RF_WE = (head_addr != 5'd0);
      RF_WA = head_addr;
      RF_WD = head_data;
    end
    if (RESET) begin
      RF_WE = 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Pending-destination scoreboard
  // ------------------------------------------------------------------
  logic [31:0] pending_q, pending_d;

  // Issue sets, pop clears; a same-cycle set on the popped bit survives.
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < 32; i++) begin
      if (pop && (head_addr == 5'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (LL_ISSUE && (LL_ISSUE_ADDR == 5'(i))) begin
        pending_d[i] = 1'b1;
      end
    end
    pending_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // RAW on either source and WAW on the destination, from registered state.
  always_comb begin
    STALL = pending_q[ID_RA1] | pending_q[ID_RA2] | (ID_WE & pending_q[ID_WA]);
  end

  assign PENDING = pending_q;

  // ------------------------------------------------------------------
  // Starvation guard
  // ------------------------------------------------------------------
  logic [3:0] starve_q, starve_d;
  logic       wb_hold_q, wb_hold_d;

  // Count cycles the head loses to WB; any pop restarts the count.
  always_comb begin
    starve_d = starve_q;
    if (pop) begin
      starve_d = 4'd0;
    end else if (!fifo_empty && WB_WE && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end
    wb_hold_d = (starve_d >= LIMIT);
  end

  // Starve counter and hold request registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      starve_q  <= 4'd0;
      wb_hold_q <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      wb_hold_q <= wb_hold_d;
    end
  end

  assign WB_HOLD  = wb_hold_q;
  assign LL_READY = !fifo_full;

endmodule

// File: tb/tb_rf_wr_sched.sv
// tb_rf_wr_sched: directed, self-checking bench for rf_wr_sched.
// Inputs change 1 time unit after a rising edge; outputs are sampled
// 1 unit later, well away from the next edge.
module tb_rf_wr_sched;

  logic        CLK;
  logic        RESET;
  logic        WB_WE;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;
  logic        WB_HOLD;
  logic        LL_ISSUE;
  logic [4:0]  LL_ISSUE_ADDR;
  logic        LL_VALID;
  logic [4:0]  LL_ADDR;
  logic [31:0] LL_DATA;
  logic        LL_READY;
  logic [4:0]  ID_RA1;
  logic [4:0]  ID_RA2;
  logic [4:0]  ID_WA;
  logic        ID_WE;
  logic        STALL;
  logic [31:0] PENDING;
  logic        RF_WE;
  logic [4:0]  RF_WA;
  logic [31:0] RF_WD;

  int pass_cnt = 0;
  int total_cnt = 0;

  rf_wr_sched #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .WB_WE(WB_WE), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .WB_HOLD(WB_HOLD),
    .LL_ISSUE(LL_ISSUE), .LL_ISSUE_ADDR(LL_ISSUE_ADDR),
    .LL_VALID(LL_VALID), .LL_ADDR(LL_ADDR), .LL_DATA(LL_DATA), .LL_READY(LL_READY),
    .ID_RA1(ID_RA1), .ID_RA2(ID_RA2), .ID_WA(ID_WA), .ID_WE(ID_WE),
    .STALL(STALL), .PENDING(PENDING),
    .RF_WE(RF_WE), .RF_WA(RF_WA), .RF_WD(RF_WD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total_cnt++; if (RF_WE !== 1'b0) $display("FAIL rst_rfwe_during: got %b want 0", RF_WE); else pass_cnt++;
    tick(); tick();
    RESET = 1'b0;
    #1;
    total_cnt++; if ({LL_READY, RF_WE, STALL, WB_HOLD} !== 4'b1000)
      $display("FAIL rst_flags: got ready/we/stall/hold=%b want 1000", {LL_READY, RF_WE, STALL, WB_HOLD}); else pass_cnt++;
    total_cnt++; if (PENDING !== 32'h0) $display("FAIL rst_pending: got %h want 0", PENDING); else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    tick(); // cycle 1
    LL_ISSUE = 1'b1; LL_ISSUE_ADDR = 5'd5; ID_RA1 = 5'd5;
    #1;
    total_cnt++; if (STALL !== 1'b0) $display("FAIL sb_stall_c1: got %b want 0", STALL); else pass_cnt++;
    tick(); // cycle 2
    LL_ISSUE = 1'b0;
    #1;
    total_cnt++; if (PENDING !== 32'h20) $display("FAIL sb_pending_c2: got %h want 00000020", PENDING); else pass_cnt++;
    total_cnt++; if (STALL !== 1'b1) $display("FAIL sb_stall_c2: got %b want 1", STALL); else pass_cnt++;
    tick(); // cycle 3: probe the other hazard terms
    ID_RA1 = 5'd0; ID_WA = 5'd5; ID_WE = 1'b0;
    #1;
    total_cnt++; if (STALL !== 1'b0) $display("FAIL sb_waw_nowe: got %b want 0", STALL); else pass_cnt++;
    ID_WE = 1'b1;
    #1;
    total_cnt++; if (STALL !== 1'b1) $display("FAIL sb_waw: got %b want 1", STALL); else pass_cnt++;
    ID_WE = 1'b0; ID_WA = 5'd0; ID_RA2 = 5'd5;
    #1;
    total_cnt++; if (STALL !== 1'b1) $display("FAIL sb_raw2: got %b want 1", STALL); else pass_cnt++;
    ID_RA2 = 5'd0; ID_RA1 = 5'd5;
    tick(); // cycle 4: result arrives
    LL_VALID = 1'b1; LL_ADDR = 5'd5; LL_DATA = 32'hDEADBEEF;
    #1;
    total_cnt++; if ({RF_WE, STALL} !== 2'b01) $display("FAIL sb_c4: got we/stall=%b want 01", {RF_WE, STALL}); else pass_cnt++;
    tick(); // cycle 5: head writes
    LL_VALID = 1'b0;
    #1;
    total_cnt++; if ({RF_WE, RF_WA, RF_WD} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL sb_write_c5: got we=%b wa=%0d wd=%h want we=1 wa=5 wd=deadbeef", RF_WE, RF_WA, RF_WD); else pass_cnt++;
    total_cnt++; if (STALL !== 1'b1) $display("FAIL sb_stall_c5: got %b want 1", STALL); else pass_cnt++;
    tick(); // cycle 6
    #1;
    total_cnt++; if ({PENDING, STALL, RF_WE} !== {32'h0, 1'b0, 1'b0})
      $display("FAIL sb_c6: got pending=%h stall=%b we=%b want 0/0/0", PENDING, STALL, RF_WE); else pass_cnt++;
    ID_RA1 = 5'd0;
  endtask

  task automatic test_set_wins();
    tick();
    LL_ISSUE = 1'b1; LL_ISSUE_ADDR = 5'd9;
    tick();
    LL_ISSUE = 1'b0; LL_VALID = 1'b1; LL_ADDR = 5'd9; LL_DATA = 32'h99;
    tick(); // head r9 pops while r9 is issued again
    LL_VALID = 1'b0; LL_ISSUE = 1'b1; LL_ISSUE_ADDR = 5'd9;
    #1;
    total_cnt++; if ({RF_WE, RF_WA} !== {1'b1, 5'd9}) $display("FAIL sw_pop: got we=%b wa=%0d want 1/9", RF_WE, RF_WA); else pass_cnt++;
    tick();
    LL_ISSUE = 1'b0; LL_VALID = 1'b1; LL_ADDR = 5'd9; LL_DATA = 32'h9A;
    #1;
    total_cnt++; if (PENDING !== 32'h200) $display("FAIL sw_setwins: got %h want 00000200", PENDING); else pass_cnt++;
    tick();
    LL_VALID = 1'b0;
    tick();
    LL_ISSUE = 1'b1; LL_ISSUE_ADDR = 5'd0;
    #1;
    total_cnt++; if (PENDING !== 32'h0) $display("FAIL sw_clear: got %h want 0", PENDING); else pass_cnt++;
    tick();
    LL_ISSUE = 1'b0;
    #1;
    total_cnt++; if (PENDING !== 32'h0) $display("FAIL sw_r0_issue: got %h want 0", PENDING); else pass_cnt++;
  endtask

  task automatic test_starve();
    tick();
    WB_WE = 1'b1; WB_ADDR = 5'd3; WB_DATA = 32'h11;
    LL_VALID = 1'b1; LL_ADDR = 5'd7; LL_DATA = 32'h77;
    #1;
    total_cnt++; if ({RF_WE, RF_WA, RF_WD} !== {1'b1, 5'd3, 32'h11})
      $display("FAIL st_wb: got we=%b wa=%0d wd=%h want 1/3/11", RF_WE, RF_WA, RF_WD); else pass_cnt++;
    tick();
    LL_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++; if ({RF_WE, RF_WA, WB_HOLD} !== {1'b1, 5'd3, 1'b0})
        $display("FAIL st_wait%0d: got we=%b wa=%0d hold=%b want 1/3/0", i, RF_WE, RF_WA, WB_HOLD); else pass_cnt++;
      tick();
    end
    #1;
    total_cnt++; if ({WB_HOLD, RF_WA} !== {1'b1, 5'd3}) $display("FAIL st_hold: got hold=%b wa=%0d want 1/3", WB_HOLD, RF_WA); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if ({WB_HOLD, RF_WA} !== {1'b1, 5'd3}) $display("FAIL st_hold_wbwins: got hold=%b wa=%0d want 1/3", WB_HOLD, RF_WA); else pass_cnt++;
    tick();
    WB_WE = 1'b0;
    #1;
    total_cnt++; if ({RF_WE, RF_WA, RF_WD, WB_HOLD} !== {1'b1, 5'd7, 32'h77, 1'b1})
      $display("FAIL st_drain: got we=%b wa=%0d wd=%h hold=%b want 1/7/77/1", RF_WE, RF_WA, RF_WD, WB_HOLD); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if ({WB_HOLD, RF_WE} !== 2'b00) $display("FAIL st_drop: got hold/we=%b want 00", {WB_HOLD, RF_WE}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    tick();
    WB_WE = 1'b1; WB_ADDR = 5'd3; WB_DATA = 32'h11;
    LL_VALID = 1'b1; LL_ADDR = 5'd10; LL_DATA = 32'hA;
    #1;
    total_cnt++; if (LL_READY !== 1'b1) $display("FAIL bb_ready0: got %b want 1", LL_READY); else pass_cnt++;
    tick();
    LL_ADDR = 5'd11; LL_DATA = 32'hB;
    #1;
    total_cnt++; if (LL_READY !== 1'b1) $display("FAIL bb_ready1: got %b want 1", LL_READY); else pass_cnt++;
    tick();
    LL_ADDR = 5'd12; LL_DATA = 32'hC;
    #1;
    total_cnt++; if (LL_READY !== 1'b0) $display("FAIL bb_full: got %b want 0", LL_READY); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if ({LL_READY, RF_WA} !== {1'b0, 5'd3}) $display("FAIL bb_held: got ready=%b wa=%0d want 0/3", LL_READY, RF_WA); else pass_cnt++;
    tick();
    WB_WE = 1'b0;
    #1;
    total_cnt++; if ({RF_WE, RF_WA, RF_WD, LL_READY} !== {1'b1, 5'd10, 32'hA, 1'b0})
      $display("FAIL bb_pop1: got we=%b wa=%0d wd=%h ready=%b want 1/10/a/0", RF_WE, RF_WA, RF_WD, LL_READY); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if ({RF_WE, RF_WA, RF_WD, LL_READY} !== {1'b1, 5'd11, 32'hB, 1'b1})
      $display("FAIL bb_pop2: got we=%b wa=%0d wd=%h ready=%b want 1/11/b/1", RF_WE, RF_WA, RF_WD, LL_READY); else pass_cnt++;
    tick();
    LL_VALID = 1'b0;
    #1;
    total_cnt++; if ({RF_WE, RF_WA, RF_WD} !== {1'b1, 5'd12, 32'hC})
      $display("FAIL bb_pop3: got we=%b wa=%0d wd=%h want 1/12/c", RF_WE, RF_WA, RF_WD); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if ({RF_WE, LL_READY} !== 2'b01) $display("FAIL bb_empty: got we/ready=%b want 01", {RF_WE, LL_READY}); else pass_cnt++;
  endtask

  task automatic test_r0();
    tick();
    WB_WE = 1'b1; WB_ADDR = 5'd0; WB_DATA = 32'h55;
    LL_VALID = 1'b1; LL_ADDR = 5'd0; LL_DATA = 32'h66;
    #1;
    total_cnt++; if (RF_WE !== 1'b0) $display("FAIL r0_wb: got %b want 0", RF_WE); else pass_cnt++;
    tick();
    LL_DATA = 32'h67;
    tick();
    LL_VALID = 1'b0;
    #1;
    total_cnt++; if ({LL_READY, RF_WE} !== 2'b00) $display("FAIL r0_full: got ready/we=%b want 00", {LL_READY, RF_WE}); else pass_cnt++;
    tick();
    WB_WE = 1'b0;
    #1;
    total_cnt++; if (RF_WE !== 1'b0) $display("FAIL r0_head1: got %b want 0", RF_WE); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if ({RF_WE, LL_READY} !== 2'b01) $display("FAIL r0_head2: got we/ready=%b want 01", {RF_WE, LL_READY}); else pass_cnt++;
    LL_VALID = 1'b1; LL_ADDR = 5'd1; LL_DATA = 32'h1234;
    tick();
    LL_VALID = 1'b0;
    #1;
    total_cnt++; if ({RF_WE, RF_WA, RF_WD} !== {1'b1, 5'd1, 32'h1234})
      $display("FAIL r0_drained: got we=%b wa=%0d wd=%h want 1/1/1234", RF_WE, RF_WA, RF_WD); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if ({RF_WE, LL_READY} !== 2'b01) $display("FAIL r0_idle: got we/ready=%b want 01", {RF_WE, LL_READY}); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    tick();
    LL_ISSUE = 1'b1; LL_ISSUE_ADDR = 5'd5;
    tick();
    LL_ISSUE_ADDR = 5'd7;
    tick();
    LL_ISSUE = 1'b0;
    WB_WE = 1'b1; WB_ADDR = 5'd3; WB_DATA = 32'h11;
    LL_VALID = 1'b1; LL_ADDR = 5'd5; LL_DATA = 32'h5;
    tick();
    LL_ADDR = 5'd7; LL_DATA = 32'h7;
    tick();
    LL_VALID = 1'b0;
    tick(); tick(); tick(); tick();
    #1;
    total_cnt++; if ({PENDING, LL_READY, WB_HOLD} !== {32'hA0, 1'b0, 1'b1})
      $display("FAIL ar_before: got pending=%h ready=%b hold=%b want a0/0/1", PENDING, LL_READY, WB_HOLD); else pass_cnt++;
    WB_WE = 1'b0; ID_RA1 = 5'd5;
    #1;
    total_cnt++; if ({RF_WE, RF_WA, STALL} !== {1'b1, 5'd5, 1'b1})
      $display("FAIL ar_head: got we=%b wa=%0d stall=%b want 1/5/1", RF_WE, RF_WA, STALL); else pass_cnt++;
    #1;
    RESET = 1'b1;
    #1;
    total_cnt++; if ({PENDING, LL_READY, RF_WE, WB_HOLD, STALL} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL ar_clear: got pending=%h ready=%b we=%b hold=%b stall=%b want 0/1/0/0/0",
               PENDING, LL_READY, RF_WE, WB_HOLD, STALL); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (RF_WE !== 1'b0) $display("FAIL ar_in_reset: got %b want 0", RF_WE); else pass_cnt++;
    RESET = 1'b0; ID_RA1 = 5'd0;
    #1;
    total_cnt++; if ({RF_WE, PENDING} !== {1'b0, 32'h0}) $display("FAIL ar_release: got we=%b pending=%h want 0/0", RF_WE, PENDING); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if ({RF_WE, LL_READY} !== 2'b01) $display("FAIL ar_after: got we/ready=%b want 01", {RF_WE, LL_READY}); else pass_cnt++;
  endtask

  initial begin
    RESET = 1'b1;
    WB_WE = 1'b0; WB_ADDR = 5'd0; WB_DATA = 32'd0;
    LL_ISSUE = 1'b0; LL_ISSUE_ADDR = 5'd0;
    LL_VALID = 1'b0; LL_ADDR = 5'd0; LL_DATA = 32'd0;
    ID_RA1 = 5'd0; ID_RA2 = 5'd0; ID_WA = 5'd0; ID_WE = 1'b0;

    test_reset();
    test_scoreboard();
    test_set_wins();
    test_starve();
    test_back_to_back();
    test_r0();
    test_async_reset();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rf_wr_sched.md
Name: rf_wr_sched

Overview:
- Write-port scheduler for the single-write-port CPU register file.
- Shares the write port between the in-order pipeline WB stage and a long-latency unit (multiply/divide, coprocessor). Long-latency results are buffered in a small FIFO.
- Keeps a pending-destination scoreboard and raises decode stalls on RAW/WAW hazards against outstanding long-latency ops.
- Sits between WB, the long-latency unit, decode hazard logic and the register file write port.

Parameters:
- FIFO_DEPTH, 2, long-latency result buffer entries; power of two, >= 2.
- STARVE_LIMIT, 4, cycles a non-empty FIFO head may wait before WB_HOLD is raised; range 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous reset, active-high.
- WB_WE  in  1  pipeline writeback valid.
- WB_ADDR  in  5  pipeline writeback register.
- WB_DATA  in  32  pipeline writeback data.
- WB_HOLD  out  1  request to pipeline to leave WB_WE low so the FIFO can drain.
- LL_ISSUE  in  1  long-latency op issued from decode this cycle.
- LL_ISSUE_ADDR  in  5  destination of the issued op.
- LL_VALID  in  1  long-latency result valid.
- LL_ADDR  in  5  result destination.
- LL_DATA  in  32  result data.
- LL_READY  out  1  FIFO can accept a result.
- ID_RA1  in  5  decode read address 1.
- ID_RA2  in  5  decode read address 2.
- ID_WA  in  5  decode destination.
- ID_WE  in  1  decode instruction writes ID_WA.
- STALL  out  1  decode hazard against a pending register.
- PENDING  out  32  scoreboard vector; bit i set means ri is awaiting a long-latency result.
- RF_WE  out  1  register file write enable.
- RF_WA  out  5  register file write address.
- RF_WD  out  32  register file write data.

Behaviour:
- Reset (async, immediate): FIFO empty, PENDING=0, starve counter=0, WB_HOLD=0, LL_READY=1, STALL=0, RF_WE=0.
  - RF_WE is also forced 0 for as long as RESET is high.
  - A reset mid-drain discards all buffered results and clears the scoreboard.
- FIFO push: LL_VALID & LL_READY at edge N.
  - LL_READY = !full, computed from registered occupancy only. A pop in the same cycle does not let a full FIFO accept.
  - LL_VALID while LL_READY=0 is ignored. The producer holds the result until accepted.
- No fall-through: a result pushed at edge N is eligible to write to the register file at the earliest in cycle N+1.
- Write port select (combinational, same cycle):
  - WB_WE=1: RF_WE/RF_WA/RF_WD come from WB. The FIFO head waits. WB has absolute priority because the pipeline cannot stall at WB.
  - WB_WE=0 and FIFO non-empty: the head drives the write port and is popped at the edge.
  - Otherwise RF_WE=0, RF_WA=0, RF_WD=0.
- Register 0:
  - A WB write to r0 gives RF_WE=0.
  - A FIFO head for r0 is popped with RF_WE=0; it still consumes its slot.
- Scoreboard:
  - LL_ISSUE with LL_ISSUE_ADDR!=0 sets PENDING[addr] at the edge.
  - A FIFO pop clears PENDING[head addr] at the edge.
  - Set and clear of the same bit in the same cycle: set wins.
  - PENDING[0] is always 0.
- STALL (combinational): PENDING[ID_RA1] | PENDING[ID_RA2] | (ID_WE & PENDING[ID_WA]).
  - STALL is computed from the registered PENDING, so in the pop cycle it is still 1. Decode re-reads the next cycle.
  - Because of the WAW term, WB never writes a register that is pending.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and WB_WE=1.
  - It resets to 0 on any pop, and holds while the FIFO is empty.
  - When counter >= STARVE_LIMIT, WB_HOLD=1 (registered).
  - WB_HOLD stays 1 until the pop edge and drops the following cycle.
  - WB still wins if WB_WE=1 while WB_HOLD=1. The head writes in the first cycle WB_WE=0.
- Occupancy counter width is clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset release, no traffic -> LL_READY=1, RF_WE=0, PENDING=0, STALL=0, WB_HOLD=0.
- LL_ISSUE r5 at cycle 1; LL_VALID r5 data 0xDEADBEEF at cycle 4, WB idle -> PENDING[5]=1 from cycle 2. Then RF_WE=1, RF_WA=5, RF_WD=0xDEADBEEF in cycle 5. PENDING[5]=0 from cycle 6. STALL=1 for ID_RA1=5 during cycles 2-5.
- WB_WE=1 r3 0x11 every cycle; LL result r7 pushed; STARVE_LIMIT=4 -> RF writes only r3 for 4 cycles, then WB_HOLD=1. On the first WB_WE=0 cycle r7 is written, and WB_HOLD drops the next cycle.
- Push 2 results with WB busy -> LL_READY=0. A third LL_VALID is held until the first WB_WE=0 cycle's pop plus one cycle. Written order is preserved.
- LL result to r0 and WB_WE to r0 -> RF_WE never 1. The FIFO still drains and LL_READY returns to 1.
- Assert RESET asynchronously with 2 entries buffered and PENDING=0x000000A0 -> all state clears immediately and no buffered write reaches the register file.
